fpu_share_sched: RTL and testbench

- Sequencer and arbiter that shares one combinational fsqrt unit and one fmul unit among NREQ requesters.
- Each requester issues a single-precision op (sqrt or mul) over a valid/ready channel.
- The block picks one requester round-robin and registers its operands. It holds them for LAT cycles so the combinational units meet timing as a multi-cycle path, then returns the result tagged with the requester id.
- Sits between the FPU units and the core's issue logic; one operation is in flight at a time.

---
 rtl/fpu_share_sched.sv | 258 +++++++++++++++++++++++++
 tb/tb_fpu_share_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_sched.sv
// Round-robin scheduler sharing one combinational fsqrt and one fmul among NREQ requesters.
// Optional macro FSQRT_NEG_NAN_EN: negative non-zero fsqrt operands bypass EXEC and return qNaN.
module fpu_share_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_data,
    output logic                 resp_ovf,
    output logic                 resp_udf
);

    localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_d;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant;
    logic            any_valid;
    logic            accept;
    logic            skip_exec;
    logic            op_sel;
    logic [31:0]     a_sel, b_sel;
    logic            op_q;
    logic [31:0]     a_q, b_q;
    logic [IDW-1:0]  id_q;
    logic [CNTW-1:0] cnt;

    // Round-robin search: the smallest offset from rr_ptr with a valid request wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant     = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            logic [IDW:0] pos;
            pos = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ))
                pos = pos - (IDW+1)'(NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (pos == (IDW+1)'(i) && req_valid[i]) begin
                    grant     = IDW'(i);
                    any_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        op_sel = 1'b0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                op_sel = req_op[i];
                a_sel  = req_a[32*i +: 32];
                b_sel  = req_b[32*i +: 32];
            end
        end
    end

    assign accept = (state == IDLE) && !rst && any_valid;

`ifdef FSQRT_NEG_NAN_EN
    assign skip_exec = !op_sel && a_sel[31] && (a_sel[30:0] != 31'd0);
`else
    assign skip_exec = 1'b0;
`endif

    // ---------------- fmul: round-to-nearest-even, subnormals flushed to zero ----------------
    logic [47:0]       prod;
    logic signed [9:0] mul_exp;
    logic [22:0]       mul_frac;
    logic              mul_guard, mul_sticky, mul_rnd;
    logic [23:0]       mul_frac_r;
    logic              mul_sign;
    logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic [31:0]       mul_res;
    logic              mul_ovf, mul_udf;

    always_comb begin
        mul_res  = '0;
        mul_ovf  = 1'b0;
        mul_udf  = 1'b0;
        mul_sign = a_q[31] ^ b_q[31];
        a_nan    = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        a_inf    = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        a_zero   = (a_q[30:23] == 8'h00);
        b_nan    = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        b_inf    = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        b_zero   = (b_q[30:23] == 8'h00);
        prod     = {1'b1, a_q[22:0]} * {1'b1, b_q[22:0]};
        mul_exp  = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd127;
        if (prod[47]) begin
            mul_frac   = prod[46:24];
            mul_guard  = prod[23];
            mul_sticky = |prod[22:0];
            mul_exp    = mul_exp + 10'sd1;
        end else begin
            mul_frac   = prod[45:23];
            mul_guard  = prod[22];
            mul_sticky = |prod[21:0];
        end
        mul_rnd    = mul_guard & (mul_sticky | mul_frac[0]);
        mul_frac_r = {1'b0, mul_frac} + {23'd0, mul_rnd};
        // A rounding carry leaves the fraction at zero and bumps the exponent.
        if (mul_frac_r[23])
            mul_exp = mul_exp + 10'sd1;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            mul_res = QNAN;
        else if (a_inf || b_inf)
            mul_res = {mul_sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            mul_res = {mul_sign, 31'd0};
        else if (mul_exp >= 10'sd255) begin
            mul_res = {mul_sign, 8'hFF, 23'd0};
            mul_ovf = 1'b1;
        end else if (mul_exp <= 10'sd0) begin
            mul_res = {mul_sign, 31'd0};
            mul_udf = 1'b1;
        end else
            mul_res = {mul_sign, mul_exp[7:0], mul_frac_r[22:0]};
    end

    // ---------------- fsqrt: restoring square root, one guard bit ----------------
    // Exact ties cannot occur for a square root, so the guard bit alone decides rounding.
    logic [49:0] sq_rad;
    logic [27:0] sq_rem, sq_trial;
    logic [24:0] sq_root;
    logic [7:0]  sq_exp;
    logic [22:0] sq_frac;
    logic [31:0] sqrt_res;

    always_comb begin
        sq_rad  = a_q[23] ? {2'b01, a_q[22:0], 25'd0} : {1'b1, a_q[22:0], 26'd0};
        sq_rem  = '0;
        sq_root = '0;
        sq_trial = '0;
        for (int i = 0; i < 25; i++) begin
            sq_rem   = {sq_rem[25:0], sq_rad[49:48]};
            sq_rad   = sq_rad << 2;
            sq_trial = {1'b0, sq_root, 2'b01};
            if (sq_rem >= sq_trial) begin
                sq_rem  = sq_rem - sq_trial;
                sq_root = {sq_root[23:0], 1'b1};
            end else begin
                sq_root = {sq_root[23:0], 1'b0};
            end
        end
        sq_exp  = {1'b0, a_q[30:24]} + 8'd63 + {7'd0, a_q[23]};
        sq_frac = sq_root[23:1] + {22'd0, sq_root[0]};

        if ((a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0))
            sqrt_res = QNAN;
        else if (a_q[30:23] == 8'h00)
            sqrt_res = {a_q[31], 31'd0};
        else if (a_q[31])
            sqrt_res = QNAN;
        else if (a_q[30:23] == 8'hFF)
            sqrt_res = 32'h7F80_0000;
        else
            sqrt_res = {1'b0, sq_exp, sq_frac};
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = skip_exec ? RESP : EXEC;
            EXEC:    if (cnt == '0) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            for (int i = 0; i < NREQ; i++)
                if (grant == IDW'(i))
                    req_ready[i] = 1'b1;
        end
    end

    // Operand, pointer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rr_ptr     <= '0;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_ovf   <= 1'b0;
            resp_udf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_sel;
                        a_q    <= a_sel;
                        b_q    <= b_sel;
                        id_q   <= grant;
                        rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                        cnt    <= CNTW'(LAT - 1);
                        if (skip_exec) begin
                            resp_valid <= 1'b1;
                            resp_data  <= QNAN;
                            resp_id    <= grant;
                            resp_ovf   <= 1'b0;
                            resp_udf   <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        resp_valid <= 1'b1;
                        resp_data  <= op_q ? mul_res : sqrt_res;
                        resp_id    <= id_q;
                        resp_ovf   <= op_q & mul_ovf;
                        resp_udf   <= op_q & mul_udf;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready)
                        resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_share_sched.sv
// Directed self-checking bench for fpu_share_sched (NREQ=4, LAT=2).
// Inputs change just after rising edges; outputs are sampled 1-2 time units after the edge.
module tb_fpu_share_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_op;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic                resp_valid;
    logic                resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         resp_data;
    logic                resp_ovf;
    logic                resp_udf;

    logic [31:0] a_arr [NREQ];
    logic [31:0] b_arr [NREQ];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_a[32*g +: 32] = a_arr[g];
        assign req_b[32*g +: 32] = b_arr[g];
    end

    fpu_share_sched #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .resp_udf   (resp_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns just after its accepting edge.
    task automatic issue(input logic [IDW-1:0] i, input logic op, input logic [31:0] a,
                         input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        a_arr[i]     = a;
        b_arr[i]     = b;
        req_op[i]    = op;
        req_valid[i] = 1'b1;
        #1;
        for (int c = 0; c < 32; c++) begin
            if (req_ready[i]) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        req_valid[i] = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout req=%0d got=no_accept exp=accept", i);
        end
    endtask

    // Edges after the accepting edge until resp_valid is seen (0 = set by the accepting edge).
    task automatic wait_resp(output int lat);
        lat = -1;
        if (resp_valid) begin
            lat = 0;
        end else begin
            for (int n = 1; n <= 20; n++) begin
                @(posedge clk);
                #1;
                if (resp_valid) begin
                    lat = n;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        tick();
        tick();
        total++;
        if ({resp_valid, resp_ovf, resp_udf, resp_id, resp_data} !== 37'd0) begin
            bad++;
            $display("FAIL reset_resp got v=%b id=%0d d=%h o=%b u=%b exp=all_zero",
                     resp_valid, resp_id, resp_data, resp_ovf, resp_udf);
        end
        req_valid = '0;
        rst       = 1'b0;
        tick();
    endtask

    task automatic test_fsqrt();
        int lat;
        issue(2'd0, 1'b0, 32'h4080_0000, 32'h0);
        wait_resp(lat);
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL sqrt4_latency got=%0d exp=%0d", lat, LAT);
        end
        total++;
        if ({resp_id, resp_data, resp_ovf, resp_udf} !== {2'd0, 32'h4000_0000, 2'b00}) begin
            bad++;
            $display("FAIL sqrt4_result got id=%0d d=%h o=%b u=%b exp id=0 d=40000000 o=0 u=0",
                     resp_id, resp_data, resp_ovf, resp_udf);
        end
        tick();
        issue(2'd1, 1'b0, 32'h4000_0000, 32'h0);
        wait_resp(lat);
        total++;
        if ({resp_id, resp_data} !== {2'd1, 32'h3FB5_04F3}) begin
            bad++;
            $display("FAIL sqrt2_result got id=%0d d=%h exp id=1 d=3fb504f3", resp_id, resp_data);
        end
        tick();
    endtask

    task automatic test_fmul();
        int lat;
        issue(2'd2, 1'b1, 32'h4040_0000, 32'h4000_0000);
        wait_resp(lat);
        total++;
        if ({lat == LAT, resp_id, resp_data, resp_ovf, resp_udf} !== {1'b1, 2'd2, 32'h40C0_0000, 2'b00}) begin
            bad++;
            $display("FAIL mul_3x2 got lat=%0d id=%0d d=%h o=%b u=%b exp lat=2 id=2 d=40c00000 o=0 u=0",
                     lat, resp_id, resp_data, resp_ovf, resp_udf);
        end
        tick();
        issue(2'd1, 1'b1, 32'h7F00_0000, 32'h7F00_0000);
        wait_resp(lat);
        total++;
        if ({resp_id, resp_data, resp_ovf, resp_udf} !== {2'd1, 32'h7F80_0000, 2'b10}) begin
            bad++;
            $display("FAIL mul_ovf got id=%0d d=%h o=%b u=%b exp id=1 d=7f800000 o=1 u=0",
                     resp_id, resp_data, resp_ovf, resp_udf);
        end
        tick();
        issue(2'd3, 1'b1, 32'h0080_0000, 32'h0080_0000);
        wait_resp(lat);
        total++;
        if ({resp_id, resp_data, resp_ovf, resp_udf} !== {2'd3, 32'h0000_0000, 2'b01}) begin
            bad++;
            $display("FAIL mul_udf got id=%0d d=%h o=%b u=%b exp id=3 d=00000000 o=0 u=1",
                     resp_id, resp_data, resp_ovf, resp_udf);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int gnt [6];
        int cyc [6];
        int n;
        int lat;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            a_arr[k] = 32'h3F80_0000;
            b_arr[k] = 32'h0;
        end
        req_op     = '0;
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        n = 0;
        #1;
        for (int c = 0; c < 60 && n < 6; c++) begin
            if (req_ready != '0) begin
                case (req_ready)
                    4'b0001: gnt[n] = 0;
                    4'b0010: gnt[n] = 1;
                    4'b0100: gnt[n] = 2;
                    4'b1000: gnt[n] = 3;
                    default: gnt[n] = -1;
                endcase
                cyc[n] = c;
                n++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        total++;
        if (n !== 6) begin
            bad++;
            $display("FAIL rr_accept_count got=%0d exp=6", n);
        end
        for (int k = 0; k < n; k++) begin
            total++;
            if (gnt[k] !== k % NREQ) begin
                bad++;
                $display("FAIL rr_grant_%0d got=%0d exp=%0d", k, gnt[k], k % NREQ);
            end
            if (k > 0) begin
                total++;
                if (cyc[k] - cyc[k-1] !== LAT + 2) begin
                    bad++;
                    $display("FAIL rr_spacing_%0d got=%0d exp=%0d", k, cyc[k] - cyc[k-1], LAT + 2);
                end
            end
        end
        wait_resp(lat);
        tick();
    endtask

    task automatic test_resp_stall();
        int lat;
        int stable_bad;
        resp_ready = 1'b0;
        issue(2'd3, 1'b1, 32'h3FC0_0000, 32'h4000_0000);
        wait_resp(lat);
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL stall_latency got=%0d exp=%0d", lat, LAT);
        end
        a_arr[0]     = 32'h3F80_0000;
        req_op[0]    = 1'b0;
        req_valid[0] = 1'b1;
        #1;
        stable_bad = 0;
        for (int c = 0; c < 5; c++) begin
            if ({resp_valid, resp_id, resp_data, req_ready} !== {1'b1, 2'd3, 32'h4040_0000, 4'b0000}) begin
                stable_bad++;
                $display("FAIL stall_hold cycle=%0d got v=%b id=%0d d=%h rdy=%b exp v=1 id=3 d=40400000 rdy=0000",
                         c, resp_valid, resp_id, resp_data, req_ready);
            end
            tick();
        end
        total++;
        if (stable_bad != 0) bad++;
        resp_ready = 1'b1;
        tick();
        total++;
        if ({resp_valid, req_ready} !== {1'b0, 4'b0001}) begin
            bad++;
            $display("FAIL stall_release got v=%b rdy=%b exp v=0 rdy=0001", resp_valid, req_ready);
        end
        // Withdrawing before acceptance must leave no trace.
        req_valid[0] = 1'b0;
        #1;
        tick();
        tick();
        total++;
        if ({resp_valid, req_ready} !== {1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL withdraw_no_effect got v=%b rdy=%b exp v=0 rdy=0000", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_exec();
        int lat;
        int spur;
        resp_ready = 1'b1;
        issue(2'd0, 1'b0, 32'h4080_0000, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_valid got=%b exp=0", resp_valid);
        end
        spur = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) spur++;
            tick();
        end
        total++;
        if (spur != 0) begin
            bad++;
            $display("FAIL abort_no_resp got=%0d_cycles_valid exp=0", spur);
        end
        a_arr[0]  = 32'h4110_0000;
        a_arr[1]  = 32'h3F80_0000;
        req_op    = '0;
        req_valid = 4'b0011;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL abort_ptr_reset got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        wait_resp(lat);
        total++;
        if ({resp_id, resp_data} !== {2'd0, 32'h4040_0000}) begin
            bad++;
            $display("FAIL after_abort_result got id=%0d d=%h exp id=0 d=40400000", resp_id, resp_data);
        end
        tick();
    endtask

    task automatic test_neg_sqrt();
        int lat;
        int exp_lat;
`ifdef FSQRT_NEG_NAN_EN
        exp_lat = 0;  // the accepting edge itself raises resp_valid
`else
        exp_lat = LAT;
`endif
        issue(2'd1, 1'b0, 32'hC080_0000, 32'h0);
        wait_resp(lat);
        total++;
        if ({lat == exp_lat, resp_id, resp_data, resp_ovf, resp_udf} !== {1'b1, 2'd1, 32'h7FC0_0000, 2'b00}) begin
            bad++;
            $display("FAIL neg_sqrt got lat=%0d id=%0d d=%h o=%b u=%b exp lat=%0d id=1 d=7fc00000 o=0 u=0",
                     lat, resp_id, resp_data, resp_ovf, resp_udf, exp_lat);
        end
        tick();
        issue(2'd2, 1'b0, 32'h8000_0000, 32'h0);
        wait_resp(lat);
        total++;
        if ({lat == LAT, resp_id, resp_data} !== {1'b1, 2'd2, 32'h8000_0000}) begin
            bad++;
            $display("FAIL neg_zero_sqrt got lat=%0d id=%0d d=%h exp lat=%0d id=2 d=80000000",
                     lat, resp_id, resp_data, LAT);
        end
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_op     = '0;
        resp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            a_arr[k] = '0;
            b_arr[k] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_fsqrt();
        test_fmul();
        test_round_robin();
        test_resp_stall();
        test_reset_mid_exec();
        test_neg_sqrt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
